fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side controller for the team's synchronous FIFO. Drives the FIFO's `read_enable` from its `empty` flag, absorbs the FIFO's one-cycle registered read latency, and presents words downstream on a valid/ready stream. A 2-entry output buffer sustains one word per cycle with no bubbles. The controller never reads an empty FIFO, so it cannot trigger an underrun.

## Interface
- `data_width`, default 8: FIFO word width; must match the FIFO's `input_width`.
- `count_width`, default 16: width of the delivered-word counter.

- `clock`  in  1  rising-edge clock shared with the FIFO.
- `reset`  in  1  synchronous, active-low; state clears on a rising edge where `reset`==0.
- `fifo_empty`  in  1  FIFO empty flag; registered in the FIFO, updated on the same edge as a pop.
- `fifo_data`  in  data_width  FIFO `data_out`; valid the cycle after `fifo_read_enable`; held otherwise.
- `fifo_read_enable`  out  1  pop request to the FIFO.
- `out_data`  out  data_width  head word of the output buffer.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts the word; a handshake is `out_valid && out_ready`.
- `word_count`  out  count_width  number of handshakes since reset; wraps modulo 2^count_width.

## Operation
- State:
  - `occ`: 0..2 words held in the buffer.
  - `inflight`: 1 bit; equals the previous cycle's `fifo_read_enable`.
  - The buffer itself: two `data_width` entries, head/tail pointers or a shift pair.
  - `word_count`.
- Invariant: `occ + inflight <= 2` at every edge.
- `pop` = `out_valid && out_ready`.
- Issue rule (combinational): `fifo_read_enable` = `reset && !fifo_empty && ((occ + inflight) < 2 || ((occ + inflight) == 2 && pop))`.
- Capture: when `inflight`==1, `fifo_data` is written at the tail on that edge.
- Pop: on `pop`, the head advances on the same edge. Capture and pop in the same cycle are legal; `occ` is unchanged.
- `occ_next` = `occ + inflight - pop`.
- `out_valid` = (`occ` != 0). `out_data` = head entry, or 0 when `occ`==0.
- Ordering: words leave strictly in FIFO order; no drops, no duplicates.
- `word_count` increments by 1 on each `pop` and wraps from all-ones to 0.
- `out_ready` with `out_valid`==0 has no effect. The `out_data`/`out_valid` pair stays stable until a handshake.
- Reset:
  - `occ`=0, `inflight`=0, `word_count`=0, buffer entries=0.
  - `out_valid`=0, `out_data`=0, `fifo_read_enable`=0 while `reset`==0.
  - Reset mid-operation discards buffered and in-flight words. The reader must be reset together with its FIFO.

## Timing
- Cold-start latency:
  - Cycle t: `fifo_empty` falls; `fifo_read_enable`=1 in t.
  - Cycle t+1: word on `fifo_data`, captured at the end of t+1.
  - Cycle t+2: `out_valid`=1.
- Streaming: with the FIFO non-empty and `out_ready`=1, after the 2-cycle fill there is one handshake per cycle. Steady state is `occ`=1, `inflight`=1.
- Backpressure: with `out_ready`=0, exactly 2 reads are issued, then `fifo_read_enable`=0 until a pop.
- On `out_ready` rising with `occ`=2:
  - Pop and a new read happen in the same cycle.
  - No bubble appears on `out_valid` while the FIFO stays non-empty.
- If the last FIFO word is popped in cycle t, the FIFO's `fifo_empty`=1 from t+1. There is no read in t+1, so no underrun.
- Combinational paths:
  - `fifo_empty` -> `fifo_read_enable`.
  - `out_ready` -> `fifo_read_enable`.
  - `out_valid`, `out_data` and `word_count` are registered-state outputs.

## Test plan
- **Reset**: hold `reset`=0 for 3 cycles with `fifo_empty`=0. Required: `fifo_read_enable`=0, `out_valid`=0, `word_count`=0 throughout. First read is issued in the first cycle with `reset`=1.
- **Single word**: FIFO holds 0xA5, `out_ready`=1. Required: `fifo_read_enable` high for exactly 1 cycle; `out_valid`=1 with `out_data`=0xA5 two cycles later for exactly one cycle; `word_count`=1.
- **Stream**: 16 words 0x00..0x0F, `out_ready`=1. Required: 16 consecutive handshakes in order with no gaps after the first, and `word_count`=16.
- **Backpressure**: FIFO holds 8 words, `out_ready`=0 for 10 cycles, then 1. Required:
  - Exactly 2 reads issued during the stall.
  - `out_data`=word0 held stable during the stall.
  - After release, 8 in-order handshakes on back-to-back cycles.
  - No read ever issued while `fifo_empty`=1.
- **Reset mid-stream**: 8 words, `out_ready` toggling 1/0, `reset`=0 after 3 handshakes. Required: `out_valid`=0 and `word_count`=0 on the next cycle; no stale word emitted after reset is released.
- **Counter wrap**: `count_width`=4, 20 words streamed. Required: `word_count` reads 15, then 0 after the 16th handshake, and ends at 4.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side controller with a 2-entry buffer onto a valid/ready stream
// Absorbs the FIFO's registered read latency while sustaining one word per cycle.
module fifo_stream_reader #(
  parameter int data_width  = 8,
  parameter int count_width = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fifo_empty,
  input  logic [data_width-1:0]  fifo_data,
  output logic                   fifo_read_enable,
  output logic [data_width-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [count_width-1:0] word_count
);

  logic [data_width-1:0]  r_mem [2];
  logic                   r_head;
  logic                   r_tail;
  logic                   r_inflight;
  logic [1:0]             r_occ;
  logic [count_width-1:0] r_count;

  logic       w_pop;
  logic [1:0] w_level;
  logic       w_has_room;

  assign out_valid  = reset && (r_occ != 2'd0);
  assign out_data   = out_valid ? r_mem[r_head] : '0;
  assign word_count = r_count;
  assign w_pop      = out_valid && out_ready;

  // Words already held plus the one arriving next cycle must never exceed the two slots.
  assign w_level          = r_occ + {1'b0, r_inflight};
  assign w_has_room       = (w_level < 2'd2) || ((w_level == 2'd2) && w_pop);
  assign fifo_read_enable = reset && !fifo_empty && w_has_room;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_count    <= '0;
    end else begin
      r_inflight <= fifo_read_enable;
      if (r_inflight) begin
        r_mem[r_tail] <= fifo_data;
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_head  <= ~r_head;
        r_count <= r_count + {{(count_width-1){1'b0}}, 1'b1};
      end
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed scoreboard bench for fifo_stream_reader
// Two instances: default counter width, and a 4-bit counter for the wrap case.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        empty_a = 1'b1;
  logic [7:0]  fdata_a = 8'h00;
  logic        re_a, valid_a, ready_a;
  logic [7:0]  odata_a;
  logic [15:0] wc_a;

  logic        empty_b = 1'b1;
  logic [7:0]  fdata_b = 8'h00;
  logic        re_b, valid_b, ready_b;
  logic [7:0]  odata_b;
  logic [3:0]  wc_b;

  fifo_stream_reader #(.data_width(8), .count_width(16)) dut_a (
    .clock(clk), .reset(rst_n), .fifo_empty(empty_a), .fifo_data(fdata_a),
    .fifo_read_enable(re_a), .out_data(odata_a), .out_valid(valid_a),
    .out_ready(ready_a), .word_count(wc_a)
  );

  fifo_stream_reader #(.data_width(8), .count_width(4)) dut_b (
    .clock(clk), .reset(rst_n), .fifo_empty(empty_b), .fifo_data(fdata_b),
    .fifo_read_enable(re_b), .out_data(odata_b), .out_valid(valid_b),
    .out_ready(ready_b), .word_count(wc_b)
  );

  logic [7:0] fq_a[$];
  logic [7:0] sb_a[$];
  logic [7:0] fq_b[$];
  logic [7:0] sb_b[$];

  // Behavioural synchronous FIFOs: registered data_out and empty flag.
  always @(posedge clk) begin
    if (re_a && fq_a.size() != 0) fdata_a <= fq_a.pop_front();
    empty_a <= (fq_a.size() == 0);
  end

  always @(posedge clk) begin
    if (re_b && fq_b.size() != 0) fdata_b <= fq_b.pop_front();
    empty_b <= (fq_b.size() == 0);
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int reads_a, vcnt_a, first_v_a, first_re_a, first_hs_a, last_hs_a, hs_a, hs_b;
  logic [15:0] exp_wc_a = 16'd0;
  logic [3:0]  exp_wc_b = 4'd0;
  logic [3:0]  prev_wc_b = 4'd0;
  logic        saw_wrap = 1'b0;
  logic        wc_known = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    reads_a = 0; vcnt_a = 0; first_v_a = -1; first_re_a = -1;
    first_hs_a = -1; last_hs_a = -1; hs_a = 0; hs_b = 0;
  endtask

  // Called at a falling edge after inputs are driven; samples before the next rising edge.
  task automatic tick();
    logic [7:0] e;
    #2;
    cyc++;
    if (!rst_n) begin
      chk("rst_no_read_a", re_a, 0);
      chk("rst_no_valid_a", valid_a, 0);
    end
    if (re_a) begin
      chk("no_underrun_a", empty_a, 0);
      reads_a++;
      if (first_re_a < 0) first_re_a = cyc;
    end
    if (re_b) chk("no_underrun_b", empty_b, 0);
    if (wc_known) begin
      chk("word_count_a", wc_a, exp_wc_a);
      chk("word_count_b", wc_b, exp_wc_b);
      if (prev_wc_b == 4'd15 && wc_b == 4'd0) saw_wrap = 1'b1;
      prev_wc_b = wc_b;
    end
    if (valid_a) begin
      vcnt_a++;
      if (first_v_a < 0) first_v_a = cyc;
    end
    if (valid_a && ready_a) begin
      chk("sb_a_has_word", sb_a.size() != 0, 1);
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        chk("data_a", odata_a, e);
      end
      hs_a++;
      exp_wc_a = exp_wc_a + 16'd1;
      if (first_hs_a < 0) first_hs_a = cyc;
      last_hs_a = cyc;
    end
    if (valid_b && ready_b) begin
      chk("sb_b_has_word", sb_b.size() != 0, 1);
      if (sb_b.size() != 0) begin
        e = sb_b.pop_front();
        chk("data_b", odata_b, e);
      end
      hs_b++;
      exp_wc_b = exp_wc_b + 4'd1;
    end
    if (!rst_n) begin
      exp_wc_a = 16'd0;
      exp_wc_b = 4'd0;
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    ready_a = 1'b0;
    ready_b = 1'b0;
    clr();

    // Reset with a non-empty FIFO holding the single-word test's word.
    fq_a.push_back(8'hA5);
    sb_a.push_back(8'hA5);
    tick();
    wc_known = 1'b1;
    tick();
    tick();
    chk("reset_word_count", wc_a, 0);

    // Single word
    clr();
    rst_n   = 1'b1;
    ready_a = 1'b1;
    #1 chk("first_read_after_reset", re_a, 1);
    repeat (6) tick();
    chk("single_reads", reads_a, 1);
    chk("single_latency", first_v_a - first_re_a, 2);
    chk("single_valid_cycles", vcnt_a, 1);
    chk("single_handshakes", hs_a, 1);
    chk("single_word_count", wc_a, 1);

    // Stream of 16 words
    clr();
    for (int i = 0; i < 16; i++) begin
      fq_a.push_back(8'(i));
      sb_a.push_back(8'(i));
    end
    n = 0;
    while (hs_a < 16 && n < 60) begin tick(); n++; end
    chk("stream_handshakes", hs_a, 16);
    chk("stream_no_gaps", last_hs_a - first_hs_a, 15);
    tick();
    chk("stream_word_count", wc_a, 17);

    // Backpressure
    clr();
    ready_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fq_a.push_back(8'h30 + 8'(i));
      sb_a.push_back(8'h30 + 8'(i));
    end
    repeat (10) begin
      tick();
      if (valid_a) chk("stall_hold_data", odata_a, 8'h30);
    end
    chk("stall_reads", reads_a, 2);
    chk("stall_valid", valid_a, 1);
    ready_a = 1'b1;
    n = 0;
    while (hs_a < 8 && n < 40) begin tick(); n++; end
    chk("release_handshakes", hs_a, 8);
    chk("release_back_to_back", last_hs_a - first_hs_a, 7);
    repeat (3) tick();

    // Reset mid-stream
    clr();
    for (int i = 0; i < 8; i++) begin
      fq_a.push_back(8'h40 + 8'(i));
      sb_a.push_back(8'h40 + 8'(i));
    end
    ready_a = 1'b0;
    n = 0;
    while (hs_a < 3 && n < 60) begin ready_a = ~ready_a; tick(); n++; end
    chk("midreset_handshakes", hs_a, 3);
    rst_n = 1'b0;
    fq_a.delete();
    sb_a.delete();
    tick();
    chk("midreset_valid", valid_a, 0);
    chk("midreset_word_count", wc_a, 0);
    rst_n   = 1'b1;
    ready_a = 1'b1;
    repeat (6) begin
      tick();
      chk("post_reset_no_valid", valid_a, 0);
    end

    // Counter wrap on the 4-bit instance
    clr();
    for (int i = 0; i < 20; i++) begin
      fq_b.push_back(8'h80 + 8'(i));
      sb_b.push_back(8'h80 + 8'(i));
    end
    ready_b = 1'b1;
    n = 0;
    while (hs_b < 20 && n < 80) begin tick(); n++; end
    chk("wrap_handshakes", hs_b, 20);
    tick();
    chk("wrap_15_to_0", saw_wrap, 1);
    chk("wrap_final_count", wc_b, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
